// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_pkg
//  Description : Shared instruction-fetch definitions. Holds the cache line
//                geometry and the line-fill state encoding. Imported by the
//                line-fill engine, the icache and the fetch-control unit.
//  Contents    : LINE_WORDS   - 32-bit words per cache line
//                LINE_BITS    - line width in bits
//                OFFSET_W     - byte-offset bits within a line
//                fill_state_t - fill engine state type (ST_IDLE, ST_FETCH)
//  Revision    : 1.0 - initial release
// ============================================================================
package ifetch_pkg;

    localparam int LINE_WORDS = 4;
    localparam int LINE_BITS  = 32 * LINE_WORDS;
    localparam int OFFSET_W   = $clog2(4 * LINE_WORDS);

    // Fill engine state encoding
    typedef logic [0:0] fill_state_t;
    localparam fill_state_t ST_IDLE  = 1'b0;
    localparam fill_state_t ST_FETCH = 1'b1;

endpackage : ifetch_pkg
`default_nettype wire

// File: rtl/icache_line_fill.sv
`default_nettype none
// ============================================================================
//  Module      : icache_line_fill
//  Description : Refill engine between the icache miss port and a 32-bit
//                instruction memory bus. Fetches one line as LINE_WORDS
//                sequential beats, assembles it in a shadow register and
//                publishes it with a one-cycle ready pulse. A new request
//                while busy redirects the fill to the new line.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                fill_req_i        - one-cycle line request pulse
//                fill_addr_i       - line address (offset bits ignored)
//                fill_ready_o      - one-cycle pulse, fill_data_o is valid
//                fill_data_o       - assembled line, word k at [32k+31:32k]
//                fill_busy_o       - fill in progress
//                bus_req_o         - read request, held until bus_rvalid_i
//                bus_addr_o        - word address of current beat
//                bus_rvalid_i      - read data valid / beat acknowledge
//                bus_rdata_i       - read data
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_line_fill #(
    parameter int LINE_WORDS = ifetch_pkg::LINE_WORDS,
    parameter int ADDR_W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fill_req_i,
    input  logic [ADDR_W-1:0]        fill_addr_i,
    output logic                     fill_ready_o,
    output logic [32*LINE_WORDS-1:0] fill_data_o,
    output logic                     fill_busy_o,
    output logic                     bus_req_o,
    output logic [ADDR_W-1:0]        bus_addr_o,
    input  logic                     bus_rvalid_i,
    input  logic [31:0]              bus_rdata_i
);

    import ifetch_pkg::*;

    localparam int c_offset_w = $clog2(4 * LINE_WORDS);
    localparam int c_beat_w   = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0]   c_offset_mask =
        ADDR_W'((64'd1 << c_offset_w) - 64'd1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    fill_state_t                          r_state;
    logic [c_beat_w-1:0]                  r_beat;
    logic [ADDR_W-1:0]                    r_base;     // line base of the active fill
    logic [ADDR_W-1:0]                    r_pend;     // redirect target awaiting the in-flight beat
    logic                                 r_restart;
    logic [LINE_WORDS-1:0][31:0]          r_shadow;   // partial line, never exposed
    logic [LINE_WORDS-1:0][31:0]          r_line;
    logic                                 r_ready;

    fill_state_t                          w_state_nxt;
    logic [c_beat_w-1:0]                  w_beat_nxt;
    logic [ADDR_W-1:0]                    w_base_nxt;
    logic [ADDR_W-1:0]                    w_pend_nxt;
    logic                                 w_restart_nxt;
    logic [LINE_WORDS-1:0][31:0]          w_shadow_nxt;
    logic [LINE_WORDS-1:0][31:0]          w_line_nxt;
    logic                                 w_ready_nxt;
    logic [ADDR_W-1:0]                    w_req_base;

    assign w_req_base = fill_addr_i & ~c_offset_mask;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_beat_nxt    = r_beat;
        w_base_nxt    = r_base;
        w_pend_nxt    = r_pend;
        w_restart_nxt = r_restart;
        w_shadow_nxt  = r_shadow;
        w_line_nxt    = r_line;
        w_ready_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (fill_req_i) begin
                    w_state_nxt   = ST_FETCH;
                    w_beat_nxt    = '0;
                    w_base_nxt    = w_req_base;
                    w_restart_nxt = 1'b0;
                end
            end

            ST_FETCH: begin
                if (bus_rvalid_i) begin
                    if (fill_req_i) begin
                        // The in-flight beat completes this cycle, so a
                        // redirect arriving with it can restart at once.
                        // This also covers a request on the final beat:
                        // the old line is dropped without a ready pulse.
                        w_beat_nxt    = '0;
                        w_base_nxt    = w_req_base;
                        w_restart_nxt = 1'b0;
                    end else if (r_restart) begin
                        // Data belongs to the abandoned line: discard it.
                        w_beat_nxt    = '0;
                        w_base_nxt    = r_pend;
                        w_restart_nxt = 1'b0;
                    end else begin
                        w_shadow_nxt[r_beat] = bus_rdata_i;
                        if (r_beat == c_last_beat) begin
                            w_line_nxt  = w_shadow_nxt;
                            w_ready_nxt = 1'b1;
                            w_state_nxt = ST_IDLE;
                            w_beat_nxt  = '0;
                        end else begin
                            w_beat_nxt  = r_beat + 1'b1;
                        end
                    end
                end else if (fill_req_i) begin
                    // Beat still outstanding: remember the target, last wins.
                    w_pend_nxt    = w_req_base;
                    w_restart_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_beat    <= '0;
            r_base    <= '0;
            r_pend    <= '0;
            r_restart <= 1'b0;
            r_shadow  <= '0;
            r_line    <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_beat    <= w_beat_nxt;
            r_base    <= w_base_nxt;
            r_pend    <= w_pend_nxt;
            r_restart <= w_restart_nxt;
            r_shadow  <= w_shadow_nxt;
            r_line    <= w_line_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Beat address is the line base with the beat index in the word field;
    // the index never exceeds the line, so no carry reaches the base.
    assign bus_addr_o   = r_base | {{(ADDR_W-c_beat_w-2){1'b0}}, r_beat, 2'b00};
    assign bus_req_o    = (r_state == ST_FETCH);
    assign fill_busy_o  = (r_state == ST_FETCH);
    assign fill_ready_o = r_ready;
    assign fill_data_o  = r_line;

endmodule : icache_line_fill
`default_nettype wire

// File: tb/tb_icache_line_fill.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_line_fill
//  Description : Directed self-checking bench for icache_line_fill. A bus
//                responder returns data a programmable number of cycles
//                after each beat is presented and logs the acknowledged
//                addresses; a monitor records ready pulses and busy cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_line_fill;

    logic         clk = 1'b0;
    logic         rst;
    logic         fill_req;
    logic [31:0]  fill_addr;
    logic         fill_ready;
    logic [127:0] fill_data;
    logic         fill_busy;
    logic         bus_req;
    logic [31:0]  bus_addr;
    logic         bus_rvalid = 1'b0;
    logic [31:0]  bus_rdata  = 32'h0;

    int           n_vec  = 0;
    int           n_miss = 0;

    int           cyc       = 0;
    int           wait_n    = 0;
    int           wcnt      = 0;
    int           ready_cnt = 0;
    int           ready_cyc = 0;
    int           busy_cnt  = 0;
    int           req_cyc   = 0;
    logic [127:0] last_line = '0;
    logic [31:0]  addr_log[$];

    icache_line_fill #(
        .LINE_WORDS (4),
        .ADDR_W     (32)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .fill_req_i   (fill_req),
        .fill_addr_i  (fill_addr),
        .fill_ready_o (fill_ready),
        .fill_data_o  (fill_data),
        .fill_busy_o  (fill_busy),
        .bus_req_o    (bus_req),
        .bus_addr_o   (bus_addr),
        .bus_rvalid_i (bus_rvalid),
        .bus_rdata_i  (bus_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [31:0] bus_data(input logic [31:0] a);
        if (a[31:4] == 28'h123)
            return 32'hA0 + {30'd0, a[3:2]};
        return 32'hC0DE_0000 | {16'd0, a[15:0]};
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Bus responder and output monitor, evaluated just after each edge.
    always begin
        @(posedge clk);
        #1;
        if (fill_ready) begin
            ready_cnt++;
            ready_cyc = cyc;
            last_line = fill_data;
        end
        if (fill_busy) busy_cnt++;
        if (!bus_req) begin
            bus_rvalid = 1'b0;
            wcnt       = 0;
        end else if (wcnt >= wait_n) begin
            bus_rvalid = 1'b1;
            bus_rdata  = bus_data(bus_addr);
            addr_log.push_back(bus_addr);
            wcnt       = 0;
        end else begin
            bus_rvalid = 1'b0;
            wcnt++;
        end
    end

    always @(negedge clk) begin
        if (bus_rvalid && !bus_req)
            check_eq("proto_rvalid_without_req", {127'd0, bus_req}, 128'd1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        addr_log.delete();
        ready_cnt = 0;
        busy_cnt  = 0;
    endtask

    task automatic issue(input logic [31:0] a);
        fill_req  = 1'b1;
        fill_addr = a;
        req_cyc   = cyc;
        @(negedge clk);
        fill_req  = 1'b0;
        fill_addr = 32'hDEAD_BEEF;
    endtask

    task automatic wait_ready(input string tag, input int exp_cnt);
        int budget = 200;
        while (ready_cnt < exp_cnt && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0)
            check_eq({tag, "_ready_timeout"}, ready_cnt, exp_cnt);
    endtask

    task automatic wait_addr(input string tag, input logic [31:0] a);
        int budget = 100;
        while (bus_addr !== a && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0)
            check_eq({tag, "_addr_timeout"}, bus_addr, a);
    endtask

    task automatic check_log(input string tag, input int n,
                             input logic [31:0] a0, input logic [31:0] a1,
                             input logic [31:0] a2, input logic [31:0] a3,
                             input logic [31:0] a4, input logic [31:0] a5,
                             input logic [31:0] a6, input logic [31:0] a7);
        logic [31:0] e[8];
        e = '{a0, a1, a2, a3, a4, a5, a6, a7};
        check_eq({tag, "_nbeats"}, addr_log.size(), n);
        for (int i = 0; i < n; i++)
            check_eq($sformatf("%s_addr%0d", tag, i), addr_log[i], e[i]);
    endtask

    initial begin
        rst       = 1'b1;
        fill_req  = 1'b0;
        fill_addr = 32'h0;
        tick(3);
        check_eq("rst_ready", fill_ready, 0);
        check_eq("rst_data",  fill_data,  0);
        check_eq("rst_busy",  fill_busy,  0);
        check_eq("rst_breq",  bus_req,    0);
        check_eq("rst_baddr", bus_addr,   0);
        rst = 1'b0;
        tick(2);

        // 1: zero-wait fill
        wait_n = 0;
        clear_logs();
        issue(32'h0000_1238);
        wait_ready("t1", 1);
        tick(3);
        check_eq("t1_nready",  ready_cnt, 1);
        check_eq("t1_latency", ready_cyc - req_cyc, 5);
        check_eq("t1_busy",    busy_cnt, 4);
        check_eq("t1_line",    last_line, 128'h000000A3_000000A2_000000A1_000000A0);
        check_eq("t1_hold",    fill_data, 128'h000000A3_000000A2_000000A1_000000A0);
        check_log("t1", 4, 32'h1230, 32'h1234, 32'h1238, 32'h123C, 0, 0, 0, 0);

        // 2: three wait states per beat
        wait_n = 3;
        clear_logs();
        issue(32'h0000_0040);
        wait_ready("t2", 1);
        tick(3);
        check_eq("t2_nready",  ready_cnt, 1);
        check_eq("t2_latency", ready_cyc - req_cyc, 17);
        check_eq("t2_busy",    busy_cnt, 16);
        check_eq("t2_line",    last_line, 128'hC0DE004C_C0DE0048_C0DE0044_C0DE0040);
        check_log("t2", 4, 32'h40, 32'h44, 32'h48, 32'h4C, 0, 0, 0, 0);

        // 3: redirect while beat 2 is outstanding; two requests, last wins
        wait_n = 2;
        clear_logs();
        issue(32'h0000_0100);
        wait_addr("t3", 32'h108);
        issue(32'h0000_0180);
        issue(32'h0000_0200);
        check_eq("t3_hold_addr", bus_addr, 32'h108);
        check_eq("t3_hold_req",  bus_req,  1);
        wait_ready("t3", 1);
        tick(3);
        check_eq("t3_nready", ready_cnt, 1);
        check_eq("t3_line",   last_line, 128'hC0DE020C_C0DE0208_C0DE0204_C0DE0200);
        check_log("t3", 7, 32'h100, 32'h104, 32'h108, 32'h200, 32'h204, 32'h208, 32'h20C, 0);

        // 4: request coincident with the final beat
        wait_n = 0;
        clear_logs();
        issue(32'h0000_0300);
        tick(3);
        check_eq("t4_last_addr", bus_addr, 32'h30C);
        issue(32'h0000_0400);
        wait_ready("t4", 1);
        tick(3);
        check_eq("t4_nready",  ready_cnt, 1);
        check_eq("t4_latency", ready_cyc - req_cyc, 5);
        check_eq("t4_line",    last_line, 128'hC0DE040C_C0DE0408_C0DE0404_C0DE0400);
        check_log("t4", 8, 32'h300, 32'h304, 32'h308, 32'h30C,
                  32'h400, 32'h404, 32'h408, 32'h40C);

        // 5: new request in the ready cycle of a prior fill
        clear_logs();
        issue(32'h0000_0480);
        tick(4);
        check_eq("t5_ready_seen", fill_ready, 1);
        check_eq("t5_line1",      fill_data, 128'hC0DE048C_C0DE0488_C0DE0484_C0DE0480);
        issue(32'h0000_0500);
        wait_ready("t5", 2);
        tick(3);
        check_eq("t5_nready",  ready_cnt, 2);
        check_eq("t5_latency", ready_cyc - req_cyc, 5);
        check_eq("t5_line2",   last_line, 128'hC0DE050C_C0DE0508_C0DE0504_C0DE0500);
        check_log("t5", 8, 32'h480, 32'h484, 32'h488, 32'h48C,
                  32'h500, 32'h504, 32'h508, 32'h50C);

        // 6: reset while beat 2 is outstanding, then a fresh fill
        wait_n = 1;
        clear_logs();
        issue(32'h0000_0600);
        wait_addr("t6", 32'h608);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_eq("t6_rst_ready", fill_ready, 0);
        check_eq("t6_rst_data",  fill_data,  0);
        check_eq("t6_rst_busy",  fill_busy,  0);
        check_eq("t6_rst_breq",  bus_req,    0);
        check_eq("t6_rst_baddr", bus_addr,   0);
        check_log("t6a", 2, 32'h600, 32'h604, 0, 0, 0, 0, 0, 0);
        tick(2);
        wait_n = 0;
        clear_logs();
        issue(32'h0000_0700);
        wait_ready("t6", 1);
        tick(3);
        check_eq("t6_nready", ready_cnt, 1);
        check_eq("t6_line",   last_line, 128'hC0DE070C_C0DE0708_C0DE0704_C0DE0700);
        check_log("t6b", 4, 32'h700, 32'h704, 32'h708, 32'h70C, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_icache_line_fill
`default_nettype wire
